// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package rv32_fetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0100_0000;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, ERR} fetch_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_e;

  // lim is the exclusive upper byte bound, one bit wider so it may reach 2^32.
  function automatic err_code_e addr_check(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] lim);
    if (addr[1:0] != 2'b00) return ERR_MISALIGN;
    if ((addr < base) || ({1'b0, addr} >= lim)) return ERR_RANGE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Clear/enable cycle counter used to bound the wait for an IMEM acknowledge.
module fetch_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count_q <= '0;
    else if (clr_i) count_q <= '0;
    else if (en_i)  count_q <= count_q + 8'd1;
  end

  assign expired_o = (count_q == 8'(TIMEOUT));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches the instruction word at each new PC from IMEM and hands it to decode.
module instr_fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE  = RESET_PC,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter int unsigned AW         = 10,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   pc_addr,
  input  logic          pc_update,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  input  logic          imem_ack,
  output logic [31:0]   instr,
  output logic [31:0]   instr_pc,
  output logic [31:0]   next_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          fetch_err,
  output logic [1:0]    err_code,
  output logic          busy,
  output logic [31:0]   fetch_count
);

  localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + 33'(IMEM_WORDS) * 33'd4;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d, cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d, valid_q, valid_d, flush_q, flush_d, ferr_q, ferr_d;
  err_code_e     code_q, code_d, pend_q, pend_d, chk, ack_code;
  logic          launch, expired, tmr_en;
  logic [31:0]   launch_pc;

  assign chk      = addr_check(pc_addr, IMEM_BASE, IMEM_END);
  assign ack_code = pc_update ? chk : pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      ipc_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      ferr_q  <= 1'b0;
      code_q  <= ERR_NONE;
      pend_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      ferr_q  <= ferr_d;
      code_q  <= code_d;
      pend_q  <= pend_d;
    end
  end

  // WAIT with req low is the one-cycle gap before reissuing a redirected fetch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ERR: if (pc_update) state_d = (chk == ERR_NONE) ? WAIT : ERR;
      WAIT: begin
        if (!req_q) begin
          if (pc_update && (chk != ERR_NONE)) state_d = ERR;
        end else if (imem_ack) begin
          if (flush_q || pc_update) begin
            if (ack_code != ERR_NONE) state_d = ERR;
          end else begin
            state_d = HOLD;
          end
        end else if (expired) begin
          state_d = ERR;
        end
      end
      HOLD: begin
        if (pc_update)        state_d = (chk == ERR_NONE) ? WAIT : ERR;
        else if (instr_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    req_d     = req_q;
    valid_d   = valid_q;
    flush_d   = flush_q;
    ferr_d    = ferr_q;
    code_d    = code_q;
    pend_d    = pend_q;
    launch    = 1'b0;
    launch_pc = pc_addr;
    case (state_q)
      IDLE, ERR, HOLD: begin
        if ((state_q == HOLD) && instr_ready) begin
          cnt_d   = cnt_q + 32'd1;
          valid_d = 1'b0;
        end
        if (pc_update) begin
          valid_d = 1'b0;
          pc_d    = pc_addr;
          ferr_d  = (chk != ERR_NONE);
          code_d  = chk;
          launch  = (chk == ERR_NONE);
        end
      end
      WAIT: begin
        if (!req_q) begin
          if (pc_update) begin
            pc_d   = pc_addr;
            ferr_d = (chk != ERR_NONE);
            code_d = chk;
            launch = (chk == ERR_NONE);
          end else begin
            launch    = 1'b1;
            launch_pc = pc_q;
          end
        end else begin
          // A redirect only records the newest address; the outstanding read runs to its ack.
          if (pc_update) begin
            pc_d    = pc_addr;
            flush_d = 1'b1;
            pend_d  = chk;
          end
          if (imem_ack) begin
            req_d   = 1'b0;
            flush_d = 1'b0;
            if (flush_q || pc_update) begin
              ferr_d = (ack_code != ERR_NONE);
              code_d = ack_code;
            end else begin
              instr_d = imem_rdata;
              ipc_d   = pc_q;
              valid_d = 1'b1;
            end
          end else if (expired) begin
            req_d   = 1'b0;
            flush_d = 1'b0;
            ferr_d  = 1'b1;
            code_d  = ERR_TIMEOUT;
          end
        end
      end
      default: ;
    endcase
    if (launch) begin
      req_d  = 1'b1;
      addr_d = AW'((launch_pc - IMEM_BASE) >> 2);
    end
  end

  // Counting the launch cycle makes the count equal the number of WAIT cycles so far.
  assign tmr_en = launch || ((state_q == WAIT) && req_q && !imem_ack);

  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!tmr_en),
    .en_i      (tmr_en),
    .expired_o (expired)
  );

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign next_pc     = ipc_q + 32'd4;
  assign instr_valid = valid_q;
  assign fetch_err   = ferr_q;
  assign err_code    = code_q;
  assign busy        = (state_q != IDLE) && (state_q != ERR);
  assign fetch_count = cnt_q;

endmodule
